// File: rtl/npe_conv_sched_pkg.sv
// Shared definitions for the NPE convolution scheduler: FSM encodings, NPE mode codes and PE count.
package npe_conv_sched_pkg;

   localparam int unsigned NpeCount = 7;
   localparam logic [3:0]  NpeModeMac = 4'h1;

   typedef enum logic [3:0] {
      StIdle  = 4'b0001,
      StLoad  = 4'b0010,
      StDrain = 4'b0100,
      StDone  = 4'b1000
   } state_e;

   // Low n bits set, one per active PE.
   function automatic logic [NpeCount-1:0] pe_mask(input logic [2:0] n);
      return NpeCount'((8'd1 << n) - 8'd1);
   endfunction

endpackage

// File: rtl/npe_conv_sched_burst_gen.sv
// Issues one contiguous i_len-beat feature burst per request; flags first and last beats.
module npe_burst_gen (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_req,
   input  logic [2:0] i_len,
   output logic       o_vld,
   output logic       o_first,
   output logic       o_last
);

   logic       active_q, active_d;
   logic [2:0] beat_q, beat_d;

   assign o_vld   = active_q;
   assign o_first = active_q && (beat_q == 3'd0);
   assign o_last  = active_q && (beat_q == i_len - 3'd1);

   always_comb begin
      active_d = active_q;
      beat_d   = beat_q;
      if (i_clr) begin
         active_d = 1'b0;
         beat_d   = 3'd0;
      end else if (active_q) begin
         if (o_last) begin
            active_d = 1'b0;
            beat_d   = 3'd0;
         end else begin
            beat_d = beat_q + 3'd1;
         end
      end else if (i_req) begin
         active_d = 1'b1;
         beat_d   = 3'd0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         active_q <= 1'b0;
         beat_q   <= 3'd0;
      end else begin
         active_q <= active_d;
         beat_q   <= beat_d;
      end
   end

endmodule

// File: rtl/npe_conv_sched.sv
// Convolution job scheduler: feeds feature bursts to the NPE PEs, strobes conv outputs per group
// and waits for all PE results before signalling completion.
module npe_conv_sched
   import npe_conv_sched_pkg::*;
#(
   parameter int unsigned PE_LAT = 2,
   parameter int unsigned NPE    = 7
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic           i_abort,
   input  logic [2:0]     i_cfg_pe_num,
   input  logic [9:0]     i_cfg_acc_len,
   input  logic [15:0]    i_cfg_out_cnt,
   input  logic [7:0]     i_src_level,
   output logic           o_src_rd,
   input  logic           i_result_vld,
   output logic [3:0]     o_npe_mode,
   output logic [NPE-1:0] o_pe_en,
   output logic           o_mdata_vld,
   output logic           o_pe_conv_out,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_err
);

   state_e             state_q, state_d;
   logic [2:0]         pe_num_q, pe_num_d;
   logic [9:0]         acc_len_q, acc_len_d;
   logic [15:0]        out_cnt_q, out_cnt_d;
   logic [9:0]         burst_cnt_q, burst_cnt_d;
   logic [15:0]        group_cnt_q, group_cnt_d;
   logic [18:0]        res_cnt_q, res_cnt_d;
   logic [PE_LAT-1:0]  sr_q, sr_d;
   logic               err_q, err_d;
   logic [18:0]        res_target;
   logic               burst_req, beat_vld, beat_first, beat_last, conv_push, busy;

   npe_burst_gen u_burst_gen (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_abort),
      .i_req   (burst_req),
      .i_len   (pe_num_q),
      .o_vld   (beat_vld),
      .o_first (beat_first),
      .o_last  (beat_last)
   );

   assign busy       = (state_q == StLoad) || (state_q == StDrain);
   assign res_target = {3'b0, out_cnt_q} * {16'b0, pe_num_q};
   // The first beat of a group's final burst launches that group's conv-out strobe.
   assign conv_push  = beat_first && (burst_cnt_q == acc_len_q - 10'd1);

   always_comb begin
      state_d     = state_q;
      pe_num_d    = pe_num_q;
      acc_len_d   = acc_len_q;
      out_cnt_d   = out_cnt_q;
      burst_cnt_d = burst_cnt_q;
      group_cnt_d = group_cnt_q;
      res_cnt_d   = res_cnt_q;
      sr_d        = (sr_q << 1) | PE_LAT'(conv_push);
      err_d       = 1'b0;
      burst_req   = 1'b0;
      if (busy && i_result_vld) res_cnt_d = res_cnt_q + 19'd1;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               if (i_cfg_pe_num == 3'd0) begin
                  err_d = 1'b1;
               end else begin
                  pe_num_d    = i_cfg_pe_num;
                  acc_len_d   = (i_cfg_acc_len == 10'd0) ? 10'd1 : i_cfg_acc_len;
                  out_cnt_d   = i_cfg_out_cnt;
                  burst_cnt_d = 10'd0;
                  group_cnt_d = 16'd0;
                  res_cnt_d   = 19'd0;
                  state_d     = (i_cfg_out_cnt == 16'd0) ? StDone : StLoad;
               end
            end
         end
         StLoad: begin
            // Registered beat_vld guarantees at least one idle cycle between bursts.
            burst_req = !beat_vld && (i_src_level >= {5'b0, pe_num_q});
            if (beat_last) begin
               if (burst_cnt_q == acc_len_q - 10'd1) begin
                  burst_cnt_d = 10'd0;
                  group_cnt_d = group_cnt_q + 16'd1;
                  if (group_cnt_q == out_cnt_q - 16'd1) state_d = StDrain;
               end else begin
                  burst_cnt_d = burst_cnt_q + 10'd1;
               end
            end
         end
         StDrain: begin
            if ((res_cnt_q == res_target) && (sr_q == '0)) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (i_abort) begin
         state_d     = StIdle;
         burst_cnt_d = 10'd0;
         group_cnt_d = 16'd0;
         res_cnt_d   = 19'd0;
         sr_d        = '0;
         err_d       = 1'b0;
         burst_req   = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         pe_num_q    <= 3'd0;
         acc_len_q   <= 10'd0;
         out_cnt_q   <= 16'd0;
         burst_cnt_q <= 10'd0;
         group_cnt_q <= 16'd0;
         res_cnt_q   <= 19'd0;
         sr_q        <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pe_num_q    <= pe_num_d;
         acc_len_q   <= acc_len_d;
         out_cnt_q   <= out_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         group_cnt_q <= group_cnt_d;
         res_cnt_q   <= res_cnt_d;
         sr_q        <= sr_d;
         err_q       <= err_d;
      end
   end

   assign o_busy        = busy;
   assign o_done        = (state_q == StDone);
   assign o_err         = err_q;
   assign o_npe_mode    = (state_q != StIdle) ? NpeModeMac : 4'h0;
   assign o_pe_en       = (state_q != StIdle) ? pe_mask(pe_num_q) : '0;
   assign o_mdata_vld   = beat_vld;
   assign o_src_rd      = beat_vld;
   assign o_pe_conv_out = sr_q[PE_LAT-1];

endmodule

// File: doc/npe_conv_sched.md
NPE_CONV_SCHED -- requirements
Module: npe_conv_sched

Interface
REQ-001 Parameter PE_LAT, default 2: cycles from first beat of a group's final burst to o_pe_conv_out.
REQ-002 Parameter NPE, default 7: number of PE MAC units. Fixed; other values unsupported.
REQ-003 i_clk  in  1  clock. i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_start  in  1  one-cycle job start; i_abort  in  1  synchronous job cancel.
REQ-005 i_cfg_pe_num  in  3  active PEs, valid 1..7; i_cfg_acc_len  in  10  bursts per output group; i_cfg_out_cnt  in  16  output groups per job.
REQ-006 i_src_level  in  8  beats available in feature source FIFO; o_src_rd  out  1  pop one beat.
REQ-007 i_result_vld  in  1  NPE result-valid strobe.
REQ-008 o_npe_mode  out  4  NPE mode; o_pe_en  out  7  PE enable mask; o_mdata_vld  out  1  feature beat valid; o_pe_conv_out  out  1  conv output strobe.
REQ-009 o_busy  out  1  job active; o_done  out  1  job-complete pulse; o_err  out  1  bad-config pulse.

Function
REQ-010 States: IDLE, LOAD, DRAIN, DONE. One-hot encoding.
REQ-011 IDLE -> LOAD on i_start with pe_num in 1..7. Latch all cfg inputs on that edge.
REQ-012 i_start with pe_num=0: stay IDLE and pulse o_err for 1 cycle, starting the next cycle.
REQ-013 i_start while not IDLE: ignored, no o_err.
REQ-014 acc_len=0 is treated as 1.
REQ-015 out_cnt=0: IDLE -> DONE directly. o_done pulses 1 cycle, then return to IDLE.
REQ-016 While not IDLE: o_npe_mode=4'h1, o_pe_en = low pe_num bits set. In IDLE both are 0.
REQ-017 Burst = pe_num consecutive cycles with o_mdata_vld=1. o_src_rd equals o_mdata_vld every cycle.
REQ-018 Burst start condition: state LOAD, no burst active, ≥1 idle cycle since the previous burst, and i_src_level ≥ pe_num.
REQ-019 A started burst is never interrupted except by i_abort.
REQ-020 A group consists of acc_len bursts.
REQ-021 o_pe_conv_out pulses exactly PE_LAT cycles after the first beat of each group's last burst. Implement with a PE_LAT-deep shift register, so pulses continue into DRAIN.
REQ-022 After the last burst of group out_cnt-1: LOAD -> DRAIN.
REQ-023 Result counter increments on every i_result_vld while busy.
REQ-024 DRAIN -> DONE when the count reaches out_cnt*pe_num (19-bit arithmetic) and the conv_out shift register is empty.
REQ-025 DONE: o_done=1 for exactly 1 cycle, then IDLE.
REQ-026 Excess i_result_vld in DONE/IDLE is ignored.
REQ-027 o_busy=1 in LOAD and DRAIN only.
REQ-028 i_abort in any state: next cycle IDLE, all counters and the shift register cleared, all outputs 0, no o_done.
REQ-029 i_abort has priority over i_start in the same cycle.
REQ-030 i_abort mid-burst truncates the burst.
REQ-031 Counters: beat 3 bits, burst 10 bits, group 16 bits, result 19 bits. Terminal detection uses equality with latched cfg; no wrap.

Reset
REQ-032 Asynchronous reset forces IDLE and clears all counters, latched cfg and the shift register.
REQ-033 During and after reset all outputs are 0 until the first i_start.
REQ-034 Reset asserted mid-job drops the job; no o_done.

Structure
REQ-035 Shared package holds: state encodings, NPE mode codes (4'h1 MAC), PE count NPE=7.
REQ-036 One sub-module, npe_burst_gen: issues one pe_num-beat burst on request and returns a last-beat flag.
REQ-037 Top level holds the FSM, group/burst/result counters and the conv_out delay line.

Verification
REQ-038 pe_num=3, acc_len=2, out_cnt=2, level held at 8, results returned 3 per group:
- 4 bursts of 3 beats, each separated by one idle cycle.
- o_pe_conv_out fires 2 cycles after burst 2 and after burst 4.
- o_done fires once, after result 6.
REQ-039 pe_num=7, acc_len=1, out_cnt=1, level=5 then raised to 7 at cycle 10 -> no o_mdata_vld before cycle 10; one 7-beat contiguous burst follows.
REQ-040 pe_num=0 start -> o_err pulse, o_busy stays 0. Then out_cnt=0 start -> o_done the cycle after LOAD is skipped, no o_mdata_vld.
REQ-041 i_abort on beat 2 of a 4-beat burst -> o_mdata_vld=0 next cycle, state IDLE, no o_done. A subsequent start runs normally.
REQ-042 i_rst_n low during DRAIN with 2 results pending -> outputs 0 immediately. Extra i_result_vld after reset release does not produce o_done.
REQ-043 i_start pulse in LOAD -> cfg unchanged, no o_err.
